// File: rtl/screen_rotate_fifo.sv
// Rotates (+90/-90) or flips (180) the video stream into a triple-buffered DDRAM framebuffer via a
// write FIFO with backpressure. Define SCREEN_ROTATE_FIFO_DROPCNT_EN to add the drop_count output.
module screen_rotate_fifo #(
    parameter logic [6:0]  MEM_BASE   = 7'b0010010,
    parameter int unsigned BPP        = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        CLK_VIDEO,
    input  logic        reset,
    input  logic        CE_PIXEL,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_DE,
    input  logic        rotate_ccw,
    input  logic        no_rotate,
    input  logic        flip,
    output logic        VIDEO_ROTATED,
    output logic        FB_EN,
    output logic [4:0]  FB_FORMAT,
    output logic [11:0] FB_WIDTH,
    output logic [11:0] FB_HEIGHT,
    output logic [31:0] FB_BASE,
    output logic [13:0] FB_STRIDE,
    input  logic        FB_VBL,
    input  logic        FB_LL,
    output logic        overflow,
`ifdef SCREEN_ROTATE_FIFO_DROPCNT_EN
    output logic [15:0] drop_count,
`endif
    output logic        DDRAM_CLK,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    output logic        DDRAM_RD
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned EW = 2 + 23 + BPP;

    typedef enum logic [1:0] {ModeCw, ModeCcw, ModeFlip} mode_e;

    // Buffer index not used by either of the two given indices.
    function automatic logic [1:0] free_buf(input logic [1:0] a, input logic [1:0] b);
        if (a != 2'd0 && b != 2'd0) return 2'd0;
        if (a != 2'd1 && b != 2'd1) return 2'd1;
        return 2'd2;
    endfunction

    logic        vs_q, de_q, vbl_q;
    logic [11:0] x_q, y_q, h_last_q, hsz_q, vsz_q;
    mode_e       mode_q;
    logic [2:0]  fb_en_q;
    logic [1:0]  i_fb_q, i_fb_d, o_fb_q, o_fb_d;
    logic        rot_q;
    logic [11:0] width_q, height_q;
    logic [13:0] stride_q;
    logic        overflow_q, overflow_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];

    logic vs_rise, de_fall, vbl_rise;
    logic full, empty, we, pop, push_req, push, drop;

    assign vs_rise  = CE_PIXEL & VGA_VS & ~vs_q;
    assign de_fall  = CE_PIXEL & ~VGA_DE & de_q;
    assign vbl_rise = CE_PIXEL & FB_VBL & ~vbl_q;

    // Address mapping uses geometry and mode latched at the last VS rise.
    logic [11:0] line_len, col, row;
    logic [13:0] line_ceil, stride_c, col_off;
    logic [25:0] row_off;
    logic [22:0] pix_addr;

    assign line_len  = (mode_q == ModeFlip) ? hsz_q : vsz_q;
    assign line_ceil = ({2'b00, line_len} + 14'd3) & 14'h3ffc;
    assign stride_c  = (BPP == 16) ? {line_ceil[12:0], 1'b0} : {line_ceil[11:0], 2'b00};

    always_comb begin
        col = vsz_q - 12'd1 - y_q;
        row = x_q;
        case (mode_q)
            ModeCcw: begin
                col = y_q;
                row = hsz_q - 12'd1 - x_q;
            end
            ModeFlip: begin
                col = hsz_q - 12'd1 - x_q;
                row = vsz_q - 12'd1 - y_q;
            end
            default: ;
        endcase
    end

    assign col_off  = (BPP == 16) ? {1'b0, col, 1'b0} : {col, 2'b00};
    assign row_off  = row * stride_c;
    assign pix_addr = row_off[22:0] + {9'd0, col_off};

    logic [EW-1:0]  head;
    logic [1:0]     head_fb;
    logic [22:0]    head_addr;
    logic [BPP-1:0] pix_c, head_pix;

    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign head_fb   = head[EW-1 -: 2];
    assign head_addr = head[BPP +: 23];
    assign head_pix  = head[BPP-1:0];

    if (BPP == 16) begin : g_rgb565
        logic unused_bits;
        assign unused_bits = ^{head_addr[0], VGA_R[2:0], VGA_G[1:0], VGA_B[2:0]};
        assign pix_c     = {VGA_R[7:3], VGA_G[7:2], VGA_B[7:3]};
        assign DDRAM_DIN = {4{head_pix}};
        assign DDRAM_BE  = 8'h03 << {head_addr[2:1], 1'b0};
    end else begin : g_rgb888
        logic unused_bits;
        assign unused_bits = ^head_addr[1:0];
        assign pix_c     = {8'd0, VGA_B, VGA_G, VGA_R};
        assign DDRAM_DIN = {2{head_pix}};
        assign DDRAM_BE  = head_addr[2] ? 8'hf0 : 8'h0f;
    end

    logic unused_hs;
    assign unused_hs = VGA_HS;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign we       = ~empty & ~reset;
    assign pop      = we & ~DDRAM_BUSY;
    assign push_req = CE_PIXEL & VGA_DE & fb_en_q[2];
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
        overflow_d = drop | (overflow_q & ~vs_rise);
        i_fb_d     = i_fb_q;
        o_fb_d     = o_fb_q;
        if (FB_LL) begin
            if (vs_rise) begin
                i_fb_d = {1'b0, ~i_fb_q[0]};
                o_fb_d = {1'b0, i_fb_q[0]};
            end
        end else begin
            if (vs_rise)  i_fb_d = free_buf(i_fb_q, o_fb_q);
            if (vbl_rise) o_fb_d = free_buf(i_fb_q, o_fb_q);
        end
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            vs_q       <= 1'b0;
            de_q       <= 1'b0;
            vbl_q      <= 1'b0;
            x_q        <= 12'd0;
            y_q        <= 12'd0;
            h_last_q   <= 12'd0;
            hsz_q      <= 12'd320;
            vsz_q      <= 12'd240;
            mode_q     <= ModeCw;
            fb_en_q    <= 3'b000;
            i_fb_q     <= 2'd0;
            o_fb_q     <= 2'd1;
            rot_q      <= 1'b0;
            width_q    <= 12'd0;
            height_q   <= 12'd0;
            stride_q   <= 14'd0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (CE_PIXEL) begin
                vs_q  <= VGA_VS;
                de_q  <= VGA_DE;
                vbl_q <= FB_VBL;
            end
            if (CE_PIXEL && VGA_DE) x_q <= x_q + 12'd1;
            if (de_fall) begin
                h_last_q <= x_q;
                x_q      <= 12'd0;
                y_q      <= y_q + 12'd1;
            end
            if (vs_rise) begin
                hsz_q   <= h_last_q;
                vsz_q   <= y_q;
                y_q     <= 12'd0;
                mode_q  <= flip ? ModeFlip : (rotate_ccw ? ModeCcw : ModeCw);
                fb_en_q <= {fb_en_q[1:0], ~no_rotate | flip};
            end
            i_fb_q     <= i_fb_d;
            o_fb_q     <= o_fb_d;
            rot_q      <= ~no_rotate;
            width_q    <= line_len;
            height_q   <= (mode_q == ModeFlip) ? vsz_q : hsz_q;
            stride_q   <= stride_c;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage is flushed by the pointer reset; contents need no reset.
    always_ff @(posedge CLK_VIDEO) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {i_fb_q, pix_addr, pix_c};
    end

`ifdef SCREEN_ROTATE_FIFO_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_hold_q;

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            drop_cnt_q  <= 16'd0;
            drop_hold_q <= 16'd0;
        end else begin
            if (drop && drop_cnt_q != 16'hffff) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (vs_rise) drop_hold_q <= drop_cnt_q;
        end
    end

    assign drop_count = drop_hold_q;
`endif

    assign VIDEO_ROTATED  = rot_q;
    assign FB_EN          = fb_en_q[2];
    assign FB_FORMAT      = (BPP == 16) ? 5'b00100 : 5'b00110;
    assign FB_WIDTH       = width_q;
    assign FB_HEIGHT      = height_q;
    assign FB_BASE        = {MEM_BASE, o_fb_q, 23'd0};
    assign FB_STRIDE      = stride_q;
    assign overflow       = overflow_q;
    assign DDRAM_CLK      = CLK_VIDEO;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = {MEM_BASE, head_fb, head_addr[22:3]};
    assign DDRAM_WE       = we;
    assign DDRAM_RD       = 1'b0;

endmodule

// File: doc/screen_rotate_fifo.md
Name: screen_rotate_fifo

Overview:
- Parametrised successor to the DDRAM screen rotator: rotates the scaler-side video stream +90/-90 degrees, or flips it 180 degrees, into a triple-buffered DDRAM framebuffer.
- Adds a selectable pixel format (32 bpp or RGB565), a write FIFO that honours DDRAM_BUSY backpressure, and overflow detection.
- Sits after the arcade video mixer, in the CLK_VIDEO domain, driving the FB_* and DDRAM_* ports of the system top.

Parameters:
- MEM_BASE, 7'b0010010, DDRAM address bits [28:22]; three 8 MB buffers at 0x24000000.
- BPP, 32, output pixel size; 32 gives {8'd0,B,G,R}, 16 gives RGB565 {R[7:3],G[7:2],B[7:3]}; other values are illegal.
- FIFO_DEPTH, 16, write FIFO entries; must be a power of two and at least 4.

Ports:
- CLK_VIDEO in 1: clock; also driven out as DDRAM_CLK.
- reset in 1: synchronous, active-high.
- CE_PIXEL in 1: pixel enable.
- VGA_R/VGA_G/VGA_B in 8 each: pixel colour.
- VGA_HS/VGA_VS/VGA_DE in 1 each: sync and data enable, qualified by CE_PIXEL.
- rotate_ccw, no_rotate, flip in 1 each: mode select.
- VIDEO_ROTATED out 1: equals ~no_rotate, registered.
- FB_EN out 1, FB_FORMAT out 5, FB_WIDTH out 12, FB_HEIGHT out 12, FB_BASE out 32, FB_STRIDE out 14: framebuffer descriptor.
- FB_VBL, FB_LL in 1 each: scaler vblank and low-latency mode.
- overflow out 1: sticky pixel-drop flag for the current frame.
- DDRAM_CLK out 1, DDRAM_BUSY in 1, DDRAM_BURSTCNT out 8 (always 1), DDRAM_ADDR out 29, DDRAM_DIN out 64, DDRAM_BE out 8, DDRAM_WE out 1, DDRAM_RD out 1 (always 0).

Behaviour:
- Clocking and reset: one clock, CLK_VIDEO; reset is synchronous and active-high. All events below are sampled only when CE_PIXEL=1.
- Reset values: FIFO empty; DDRAM_WE=0; FB_EN=0; overflow=0; i_fb=0; o_fb=1; VIDEO_ROTATED=0; FB_WIDTH=0; FB_HEIGHT=0. Internal hsz=320, vsz=240, fb_en shift register=0.
- Geometry:
  - H = DE pixel count of the last line.
  - V = DE line count, latched on the VS rising edge.
  - Output line length L = V when rotating; L = H when flipping.
  - Bytes per pixel B = BPP/8.
  - FB_STRIDE = ceil(L/4)*4*B.
  - FB_WIDTH/FB_HEIGHT = V/H when rotating, H/V when flipping; updated one cycle after a geometry change.
  - FB_FORMAT = 5'b00110 for BPP 32; 5'b00100 for BPP 16.
- FB_EN: fb_en shifts in (~no_rotate | flip) on each VS rise; FB_EN = fb_en[2], so it asserts on the third frame after enable.
- Mapping for input pixel (x,y), using the geometry of the previous frame:
  - Clockwise: col = V-1-y, row = x.
  - CCW: col = y, row = H-1-x.
  - Flip: col = H-1-x, row = V-1-y.
  - Byte address = row*STRIDE + col*B, 23 bits, wraps modulo 8 MB.
- DDRAM_ADDR = {MEM_BASE, i_fb, addr[22:3]}.
  - DDRAM_DIN replicates the pixel across the 64-bit word (twice for BPP 32, four times for BPP 16).
  - DDRAM_BE selects the pixel's 4 or 2 bytes by addr[2:0].
- FIFO entry = {i_fb, addr, pixel}. The full address is captured at push, so a buffer swap never retargets queued pixels.
  - Push: CE_PIXEL & VGA_DE & FB_EN.
  - Pop: DDRAM_WE & ~DDRAM_BUSY.
- Avalon handshake: DDRAM_WE=1 whenever the FIFO is non-empty. ADDR/DIN/BE stay stable while BUSY=1. Throughput is one pop per cycle.
- Simultaneous push and pop on a full FIFO is accepted without a drop.
- Full FIFO with a push and no pop: the pixel is dropped and overflow is set. overflow clears on the next VS rise; if a drop occurs on that same cycle, set wins.
- Buffer rotation:
  - FB_LL=1: i_fb and o_fb alternate between 0 and 1.
  - FB_LL=0: i_fb advances on the VS rise and o_fb on the FB_VBL rise, each to the buffer used by neither side.
  - If both advance in the same cycle, both take their next value computed from the pre-edge values.
- Reset mid-frame flushes the FIFO; no DDRAM_WE may be asserted during reset or in the cycle after it.
- A mode change takes effect on the next VS rise; pixels already queued are still written.

Optional Feature:
- Macro: SCREEN_ROTATE_FIFO_DROPCNT_EN.
- Defined: adds output drop_count [15:0]. It counts dropped pixels, saturates at 16'hFFFF, is cleared on reset, and is latched into a hold register on each VS rise.
- Undefined: no drop_count port or counter logic; all other behaviour is identical.

Test Plan:
- BPP 32, clockwise, H=4, V=3, BUSY=0, third frame: pixel (0,0) -> addr 8, DDRAM_ADDR[2:0]… (addr[2]=1, BE=F0); pixel (3,2) -> addr 48; STRIDE=16; FB_WIDTH=3; FB_HEIGHT=4.
- CCW, same frame: (0,0) -> row 3, addr 48; (3,2) -> addr 8; flip mode, H=4, V=3: (0,0) -> addr 44 (row 2 col 3).
- BPP 16, clockwise, V=3: STRIDE=8; FB_FORMAT=00100; (0,1) col 1 -> BE=8'h0C, RGB565 of R=FF,G=00,B=00 = 16'hF800.
- BUSY held 20 cycles during a 12-pixel line with FIFO_DEPTH 16: no drops; ADDR stable while BUSY; all 12 writes in order; overflow=0.
- BUSY held through 20 pushes with FIFO_DEPTH 16: exactly 4 drops; overflow=1 until next VS rise; drop_count=4 with the macro defined.
- reset asserted mid-line with 5 entries queued: WE=0 the next two cycles; FIFO empty; FB_EN=0 until three further VS rises.
